// File: rtl/cdc_fifo_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: Gray read pointer, empty/level
// from the synchronised write pointer, RAM read issue and a 2-entry FWFT buffer.
module cdc_fifo_rd_ctrl #(
  parameter int ADDRSIZE  = 4,
  parameter int WIDTH     = 32,
  parameter int AE_THRESH = 1
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [ADDRSIZE:0]   rdq2_wrptr,
  output logic [ADDRSIZE:0]   rd_ptr,
  output logic                mem_en,
  output logic [ADDRSIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                rd_almost_empty
);
  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AE_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rd_bin_r;
  logic          inflight_r;
  logic [1:0]    occ_r;
  logic [WIDTH-1:0] tail_r;
  logic [PW-1:0] rd_bin_next_s;
  logic [PW-1:0] level_next_s;
  logic          ram_empty_s;
  logic          pop_s;
  logic          push_s;
  logic [2:0]    pending_s;
  logic [1:0]    occ_next_s;

  // Issue decision; mem_en is held low during reset even if the write pointer is stale.
  always_comb begin
    ram_empty_s   = (rd_ptr == rdq2_wrptr);
    pop_s         = out_valid & out_ready;
    push_s        = inflight_r;
    pending_s     = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    mem_en        = rd_rst & ~ram_empty_s & (pending_s < 3'd2);
    mem_addr      = rd_bin_r[ADDRSIZE-1:0];
    rd_bin_next_s = rd_bin_r + {{ADDRSIZE{1'b0}}, mem_en};
    level_next_s  = gray2bin(rdq2_wrptr) - rd_bin_next_s;
  end

  // Output buffer occupancy after this edge.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
  end

  // Read pointer, in-flight flag and level; binary and Gray update on the same edge.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rd_bin_r        <= '0;
      rd_ptr          <= '0;
      inflight_r      <= 1'b0;
      rd_level        <= '0;
      rd_almost_empty <= 1'b1;
    end else begin
      rd_bin_r        <= rd_bin_next_s;
      rd_ptr          <= bin2gray(rd_bin_next_s);
      inflight_r      <= mem_en;
      rd_level        <= level_next_s;
      rd_almost_empty <= (level_next_s <= AE_TH);
    end
  end

  // Two-entry FWFT buffer: out_data is the head, tail_r the second word.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      occ_r     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail_r    <= '0;
    end else begin
      occ_r     <= occ_next_s;
      out_valid <= (occ_next_s != 2'd0);
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            out_data <= mem_rdata;
          end else begin
            tail_r <= mem_rdata;
          end
        end
        2'b01: out_data <= tail_r;
        2'b11: begin
          if (occ_r == 2'd1) begin
            out_data <= mem_rdata;
          end else begin
            out_data <= tail_r;
            tail_r   <= mem_rdata;
          end
        end
        default: out_data <= out_data;
      endcase
    end
  end

  cdc_fifo_rd_ctrl_chk u_chk (
    .clk  (rd_clk),
    .rst  (rd_rst),
    .occ  (occ_r),
    .push (push_s),
    .pop  (pop_s)
  );
endmodule

// Simulation-only guard: the issue rule must never let the buffer overflow.
module cdc_fifo_rd_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occ,
  input logic       push,
  input logic       pop
);
  buf_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (occ == 2'd2)));
endmodule
